avalon_msg_store_forward: RTL and testbench

- Store-and-forward message buffer placed directly downstream of the Avalon-ST protocol enforcer. Consumes the enforced message stream.
- Buffers each message in an internal FIFO. No beat of a message is presented downstream until its eop beat has been written.
- Drops any message longer than the buffer, so a downstream consumer never sees a partial message or a stall inside a message.

---
 rtl/avalon_msg_store_forward_if.sv | 17 +
 rtl/avalon_msg_store_forward.sv | 160 ++++++++++++++++
 tb/tb_avalon_msg_store_forward.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_msg_store_forward_if.sv
// rtl/avalon_msg_store_forward_if.sv - Avalon-ST style message stream interface
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 8
);
  localparam int DATA_W  = 8 * DATA_WIDTH_IN_BYTES;
  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic [DATA_W-1:0]  data;
  logic               valid;
  logic               ready;
  logic               sop;
  logic               eop;
  logic [EMPTY_W-1:0] empty;

  modport master (output data, valid, sop, eop, empty, input ready);
  modport slave  (input data, valid, sop, eop, empty, output ready);
endinterface

// File: rtl/avalon_msg_store_forward.sv
// rtl/avalon_msg_store_forward.sv - store-and-forward message buffer with oversize drop
module avalon_msg_store_forward #(
  parameter int DATA_WIDTH_IN_BYTES = 8,
  parameter int DEPTH               = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  avalon_st_if.slave               in_msg,
  avalon_st_if.master              out_msg,
  output logic [$clog2(DEPTH):0]   stored_msg_count,
  output logic                     oversize_drop,
  output logic                     sop_restart
);
  localparam int DATA_W  = 8 * DATA_WIDTH_IN_BYTES;
  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;
  localparam int ENTRY_W = DATA_W + 2 + EMPTY_W;
  localparam int AW      = $clog2(DEPTH);
  localparam int OW      = AW + 1;
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

  typedef enum logic [1:0] {IDLE, STORE, DROP} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     start_q, start_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic [OW-1:0]     partial_q, partial_d;
  logic [OW-1:0]     count_q, count_d;
  logic              oversize_q, oversize_d;
  logic              restart_q, restart_d;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] rd_entry;
  logic [AW-1:0]      wr_addr;
  logic               wr_en, rewind, msg_done;
  logic               full, in_ready, in_acc;
  logic               out_valid, taken, taken_eop;
  logic [OW-1:0]      rewind_amt;

  assign full     = (occ_q == DEPTH_C);
  assign in_ready = ~full | (state_q == DROP) | ((state_q == STORE) & (partial_q == DEPTH_C));
  assign in_acc   = in_msg.valid & in_ready;
  assign in_msg.ready = in_ready;

  assign rd_entry  = mem[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign taken     = out_valid & out_msg.ready;
  assign taken_eop = taken & rd_entry[EMPTY_W];

  assign out_msg.valid = out_valid;
  assign out_msg.data  = out_valid ? rd_entry[ENTRY_W-1 -: DATA_W] : '0;
  assign out_msg.sop   = out_valid & rd_entry[EMPTY_W+1];
  assign out_msg.eop   = out_valid & rd_entry[EMPTY_W];
  assign out_msg.empty = out_valid ? rd_entry[EMPTY_W-1:0] : '0;

  assign stored_msg_count = count_q;
  assign oversize_drop    = oversize_q;
  assign sop_restart      = restart_q;

  // Write-side FSM: decide whether the accepted beat is stored, rewound over, or discarded
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    partial_d  = partial_q;
    wr_en      = 1'b0;
    rewind     = 1'b0;
    msg_done   = 1'b0;
    oversize_d = 1'b0;
    restart_d  = 1'b0;
    if (in_acc) begin
      case (state_q)
        IDLE: begin
          if (in_msg.sop) begin
            wr_en = 1'b1;
            if (in_msg.eop) begin
              msg_done = 1'b1;
            end else begin
              state_d   = STORE;
              partial_d = OW'(1);
              start_d   = wr_ptr_q;
            end
          end
        end
        STORE: begin
          if (in_msg.sop) begin
            // Abandon the partial message and reuse its first slot for the new start.
            rewind    = 1'b1;
            restart_d = 1'b1;
            wr_en     = 1'b1;
            if (in_msg.eop) begin
              msg_done  = 1'b1;
              state_d   = IDLE;
              partial_d = '0;
            end else begin
              partial_d = OW'(1);
            end
          end else if (partial_q == DEPTH_C) begin
            rewind     = 1'b1;
            oversize_d = 1'b1;
            partial_d  = '0;
            state_d    = in_msg.eop ? IDLE : DROP;
          end else begin
            wr_en     = 1'b1;
            partial_d = partial_q + OW'(1);
            if (in_msg.eop) begin
              msg_done  = 1'b1;
              state_d   = IDLE;
              partial_d = '0;
            end
          end
        end
        DROP: begin
          if (in_msg.eop) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pointer, occupancy and message-count bookkeeping derived from the FSM decision
  always_comb begin
    wr_addr    = rewind ? start_q : wr_ptr_q;
    wr_ptr_d   = wr_en ? (wr_addr + AW'(1)) : wr_addr;
    rd_ptr_d   = taken ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    rewind_amt = rewind ? partial_q : '0;
    occ_d      = occ_q + OW'(wr_en) - OW'(taken) - rewind_amt;
    count_d    = count_q + OW'(msg_done) - OW'(taken_eop);
  end

  // Beat storage; contents need no reset because valid is gated by the message count
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {in_msg.data, in_msg.sop, in_msg.eop, in_msg.empty};
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      start_q    <= '0;
      occ_q      <= '0;
      partial_q  <= '0;
      count_q    <= '0;
      oversize_q <= 1'b0;
      restart_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      start_q    <= start_d;
      occ_q      <= occ_d;
      partial_q  <= partial_d;
      count_q    <= count_d;
      oversize_q <= oversize_d;
      restart_q  <= restart_d;
    end
  end
endmodule

// File: tb/tb_avalon_msg_store_forward.sv
// tb/tb_avalon_msg_store_forward.sv - directed self-checking bench for the message buffer
module tb_avalon_msg_store_forward;
  localparam int BYTES = 8;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] stored_msg_count;
  logic       oversize_drop;
  logic       sop_restart;

  int pass_cnt = 0;
  int total = 0;

  logic [68:0] q[$];

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(BYTES)) in_if ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(BYTES)) out_if ();

  avalon_msg_store_forward #(.DATA_WIDTH_IN_BYTES(BYTES), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst_n),
    .in_msg           (in_if),
    .out_msg          (out_if),
    .stored_msg_count (stored_msg_count),
    .oversize_drop    (oversize_drop),
    .sop_restart      (sop_restart)
  );

  always #5 clk = ~clk;

  // Record every beat the consumer takes (stable at the falling edge).
  always @(negedge clk) begin
    if (out_if.valid === 1'b1 && out_if.ready === 1'b1)
      q.push_back({out_if.data, out_if.sop, out_if.eop, out_if.empty});
  end

  function automatic logic [68:0] pk(input logic [63:0] d, input logic s, input logic e,
                                     input logic [2:0] em);
    return {d, s, e, em};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic s, input logic e, input logic [2:0] em);
    int budget;
    in_if.data  = d;
    in_if.sop   = s;
    in_if.eop   = e;
    in_if.empty = em;
    in_if.valid = 1'b1;
    budget = 0;
    while (in_if.ready !== 1'b1 && budget < 200) begin
      tick();
      budget++;
    end
    if (budget >= 200) chk("send_timeout", 1, 0);
    tick();
  endtask

  task automatic idle_in();
    in_if.valid = 1'b0;
    in_if.sop   = 1'b0;
    in_if.eop   = 1'b0;
    in_if.data  = '0;
    in_if.empty = '0;
  endtask

  initial begin
    logic flag;
    idle_in();
    out_if.ready = 1'b0;

    // Reset state
    #2;
    chk("rst_valid", out_if.valid, 0);
    chk("rst_count", stored_msg_count, 0);
    chk("rst_ready", in_if.ready, 1);
    chk("rst_data", out_if.data, 0);
    chk("rst_pulses", {oversize_drop, sop_restart}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single-beat message
    out_if.ready = 1'b1;
    send(64'hA5, 1, 1, 3'd3);
    idle_in();
    chk("t1_valid", out_if.valid, 1);
    chk("t1_data", out_if.data, 64'hA5);
    chk("t1_sopeop", {out_if.sop, out_if.eop}, 2'b11);
    chk("t1_empty", out_if.empty, 3);
    chk("t1_count1", stored_msg_count, 1);
    tick();
    chk("t1_count0", stored_msg_count, 0);
    chk("t1_valid0", out_if.valid, 0);
    q.delete();

    // 4-beat message: nothing visible until eop stored
    flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(64'h10 + 64'(i), i == 0, i == 3, (i == 3) ? 3'd2 : 3'd0);
      if (i < 3 && out_if.valid !== 1'b0) flag = 1'b1;
    end
    idle_in();
    chk("t2_early_valid", flag, 0);
    chk("t2_first_vis", {out_if.valid, out_if.sop, out_if.data}, {2'b11, 64'h10});
    repeat (5) tick();
    chk("t2_qsize", q.size(), 4);
    for (int i = 0; i < 4 && i < q.size(); i++)
      chk($sformatf("t2_beat%0d", i), q[i], pk(64'h10 + 64'(i), i == 0, i == 3, (i == 3) ? 3'd2 : 3'd0));
    q.delete();

    // 17-beat oversize message followed by a 2-beat message
    flag = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_if.valid = 1'b1;
      if (in_if.ready !== 1'b1) flag = 1'b1;
      send(64'h100 + 64'(i), i == 0, i == 16, 3'd0);
      if (i == 15) chk("t3_no_early_drop", oversize_drop, 0);
    end
    chk("t3_drop_pulse", oversize_drop, 1);
    if (in_if.ready !== 1'b1) flag = 1'b1;
    send(64'h200, 1, 0, 3'd0);
    chk("t3_drop_one_cycle", oversize_drop, 0);
    if (in_if.ready !== 1'b1) flag = 1'b1;
    send(64'h201, 0, 1, 3'd1);
    idle_in();
    chk("t3_ready_always", flag, 0);
    repeat (4) tick();
    chk("t3_qsize", q.size(), 2);
    if (q.size() == 2) begin
      chk("t3_beat0", q[0], pk(64'h200, 1, 0, 3'd0));
      chk("t3_beat1", q[1], pk(64'h201, 0, 1, 3'd1));
    end
    chk("t3_occ", dut.occ_q, 0);
    q.delete();

    // Exactly DEPTH beats with consumer stalled
    out_if.ready = 1'b0;
    for (int i = 0; i < 16; i++)
      send(64'h300 + 64'(i), i == 0, i == 15, (i == 15) ? 3'd5 : 3'd0);
    idle_in();
    chk("t4_full_ready", in_if.ready, 0);
    chk("t4_count", stored_msg_count, 1);
    out_if.ready = 1'b1;
    repeat (17) tick();
    chk("t4_qsize", q.size(), 16);
    for (int i = 0; i < 16 && i < q.size(); i++)
      chk($sformatf("t4_beat%0d", i), q[i], pk(64'h300 + 64'(i), i == 0, i == 15, (i == 15) ? 3'd5 : 3'd0));
    chk("t4_ready_back", in_if.ready, 1);
    q.delete();

    // Three 5-beat messages fill 15 slots; a fourth stalls at full
    out_if.ready = 1'b0;
    for (int m = 0; m < 3; m++)
      for (int i = 0; i < 5; i++)
        send(64'h400 + 64'(16 * m + i), i == 0, i == 4, (i == 4) ? 3'd1 : 3'd0);
    chk("t5_count3", stored_msg_count, 3);
    chk("t5_ready15", in_if.ready, 1);
    send(64'h430, 1, 0, 3'd0);
    in_if.data = 64'h431;
    in_if.sop  = 1'b0;
    flag = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (in_if.ready !== 1'b0) flag = 1'b1;
      tick();
    end
    chk("t5_stalled", flag, 0);
    out_if.ready = 1'b1;
    for (int i = 1; i < 5; i++)
      send(64'h430 + 64'(i), 0, i == 4, (i == 4) ? 3'd1 : 3'd0);
    idle_in();
    repeat (25) tick();
    chk("t5_qsize", q.size(), 20);
    for (int m = 0; m < 4; m++)
      for (int i = 0; i < 5; i++)
        if (5 * m + i < q.size())
          chk($sformatf("t5_m%0d_b%0d", m, i), q[5 * m + i],
              pk(64'h400 + 64'(16 * m + i), i == 0, i == 4, (i == 4) ? 3'd1 : 3'd0));
    q.delete();

    // sop arriving mid-message restarts it
    send(64'h500, 1, 0, 3'd0);
    send(64'h501, 0, 0, 3'd0);
    chk("t6_no_restart", sop_restart, 0);
    send(64'h502, 1, 0, 3'd0);
    chk("t6_restart", sop_restart, 1);
    send(64'h503, 0, 0, 3'd0);
    chk("t6_restart_once", sop_restart, 0);
    send(64'h504, 0, 1, 3'd4);
    idle_in();
    repeat (5) tick();
    chk("t6_qsize", q.size(), 3);
    if (q.size() == 3) begin
      chk("t6_beat0", q[0], pk(64'h502, 1, 0, 3'd0));
      chk("t6_beat1", q[1], pk(64'h503, 0, 0, 3'd0));
      chk("t6_beat2", q[2], pk(64'h504, 0, 1, 3'd4));
    end
    q.delete();

    // Reset mid-stream with one stored message and one partial message
    out_if.ready = 1'b0;
    send(64'h600, 1, 0, 3'd0);
    send(64'h601, 0, 1, 3'd0);
    send(64'h610, 1, 0, 3'd0);
    send(64'h611, 0, 0, 3'd0);
    idle_in();
    chk("t7_pre_count", stored_msg_count, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", out_if.valid, 0);
    chk("t7_rst_count", stored_msg_count, 0);
    chk("t7_rst_ready", in_if.ready, 1);
    chk("t7_rst_outs", {out_if.data, out_if.sop, out_if.eop, out_if.empty}, 0);
    chk("t7_rst_pulses", {oversize_drop, sop_restart}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    out_if.ready = 1'b1;
    send(64'h612, 0, 0, 3'd0);
    send(64'h613, 0, 1, 3'd0);
    idle_in();
    repeat (6) tick();
    chk("t7_no_stale", q.size(), 0);
    chk("t7_count_after", stored_msg_count, 0);
    chk("t7_occ_after", dut.occ_q, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
